// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the four-way add/subtract arbiter.
package addsub_arb_pkg;

    // Sequencer states: pick a requester, compute, then hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    // Pointer starts at the last requester, so requester 0 is searched first.
    localparam logic [ID_W-1:0] PTR_RESET = 2'd3;

    // Expand a requester index into a one-hot accept vector.
    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four request bits. The search
// starts one past the previous winner (ptr) and wraps, so ptr itself is
// considered last and no requester can be passed over more than three times.
module rr_pick4
    import addsub_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);

    logic [ID_W-1:0] cand;

    // Scan ptr+1, ptr+2, ptr+3, ptr and keep the first requester found.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional logic; a path that leaves one unassigned infers a latch.
        gnt_valid = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // Two-bit addition wraps modulo 4, giving the circular order.
            cand = ptr + ID_W'(k);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_id    = cand;
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter and sequencer sharing one (N+1)-bit add/subtract unit
// among four requesters. One request is accepted in IDLE, computed in EXEC,
// and its result is held in RESP until the consumer takes it.
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*(N+1)-1:0]   req_x,
    input  logic [NUM_REQ*(N+1)-1:0]   req_y,
    input  logic [NUM_REQ-1:0]         req_sel,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [N+1:0]               rsp_z,
    output logic [ID_W-1:0]            rsp_id
);

    localparam int OP_W  = N + 1;
    localparam int RES_W = N + 2;

    // Sequencer state and round-robin pointer.
    state_t            state_q;
    logic [ID_W-1:0]   ptr_q;

    // Operand registers loaded on the acceptance cycle.
    logic [OP_W-1:0]   x_q;
    logic [OP_W-1:0]   y_q;
    logic              sel_q;
    logic [ID_W-1:0]   id_q;

    // Result registers driving the response port directly.
    logic [RES_W-1:0]  z_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;

    // Picker outputs and next-value operands of the current winner.
    logic              gnt_valid;
    logic [ID_W-1:0]   gnt_id;
    logic              accept;
    logic [OP_W-1:0]   x_d;
    logic [OP_W-1:0]   y_d;
    logic              sel_d;
    logic [RES_W-1:0]  z_d;

    rr_pick4 u_pick (
        .req       (req_valid),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // The winner is always a valid requester and its ready is raised in the
    // same cycle, so a grant in IDLE is an accepted handshake.
    assign accept = (state_q == IDLE) && gnt_valid;

    // Route the winner's operand slice toward the operand registers.
    always_comb begin
        x_d   = req_x[int'(gnt_id) * OP_W +: OP_W];
        y_d   = req_y[int'(gnt_id) * OP_W +: OP_W];
        sel_d = req_sel[gnt_id];
    end

    // Shared add/subtract on zero-extended operands; subtraction wraps
    // modulo 2^(N+2), so a negative difference appears as two's complement.
    always_comb begin
        if (sel_q) begin
            z_d = {1'b0, x_q} - {1'b0, y_q};
        end else begin
            z_d = {1'b0, x_q} + {1'b0, y_q};
        end
    end

    // Accept strobe: only the winner, only in IDLE, independent of rsp_ready.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready = id_to_onehot(gnt_id);
        end
    end

    // Sequencer FSM with registered response outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_RESET;
            x_q         <= '0;
            y_q         <= '0;
            sel_q       <= 1'b0;
            id_q        <= '0;
            z_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        sel_q   <= sel_d;
                        id_q    <= gnt_id;
                        ptr_q   <= gnt_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    z_q         <= z_d;
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = z_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed testbench for addsub_arbiter with N = 4 (5-bit operands, 6-bit results).
module tb_addsub_arbiter;

    localparam int N  = 4;
    localparam int OW = N + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [4*OW-1:0] req_x;
    logic [4*OW-1:0] req_y;
    logic [3:0]      req_sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [N+1:0]    rsp_z;
    logic [1:0]      rsp_id;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    addsub_arbiter #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [OW-1:0] x, input logic [OW-1:0] y,
                           input logic s);
        req_x[i*OW +: OW] = x;
        req_y[i*OW +: OW] = y;
        req_sel[i]        = s;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if (rsp_z !== 6'd0) begin n_err++; $display("FAIL reset_rsp_z got %0d want 0", rsp_z); end
        n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        tick();
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL idle_no_req_ready got %b want 0000", req_ready); end
        // Lone request from requester 0 is granted in this IDLE cycle.
        req_valid = 4'b0001;
        settle();
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL first_grant got %b want 0001", req_ready); end
        // Withdrawn before the edge: skipped, no transaction.
        req_valid = 4'b0000;
        tick();
        tick();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL withdrawn_no_rsp got %b want 0", rsp_valid); end
    endtask

    task automatic test_sub_negative();
        rsp_ready = 1'b1;
        set_req(2, 5'd3, 5'd5, 1'b1);
        req_valid = 4'b0100;
        settle();
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL sub_grant got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        settle();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL sub_exec_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL sub_exec_ready got %b want 0000", req_ready); end
        tick();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL sub_rsp_valid got %b want 1", rsp_valid); end
        n_vec++; if (rsp_z !== 6'd62) begin n_err++; $display("FAIL sub_rsp_z got %0d want 62", rsp_z); end
        n_vec++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL sub_rsp_id got %0d want 2", rsp_id); end
        tick();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL sub_rsp_clear got %b want 0", rsp_valid); end
        req_valid = 4'b0100;
        settle();
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL sub_back_idle got %b want 0100", req_ready); end
        req_valid = 4'b0000;
        settle();
    endtask

    task automatic test_add_carry();
        logic [4:0] tx [3] = '{5'd31, 5'd31, 5'd0};
        logic [4:0] ty [3] = '{5'd31, 5'd1, 5'd0};
        logic       ts [3] = '{1'b0, 1'b0, 1'b1};
        logic [5:0] tz [3] = '{6'd62, 6'd32, 6'd0};
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(1, tx[k], ty[k], ts[k]);
            req_valid = 4'b0010;
            settle();
            n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL addc_grant[%0d] got %b want 0010", k, req_ready); end
            tick();
            req_valid = 4'b0000;
            tick();
            n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL addc_rsp_valid[%0d] got %b want 1", k, rsp_valid); end
            n_vec++; if (rsp_z !== tz[k]) begin n_err++; $display("FAIL addc_rsp_z[%0d] got %0d want %0d", k, rsp_z, tz[k]); end
            n_vec++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL addc_rsp_id[%0d] got %0d want 1", k, rsp_id); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [5:0] exp_z [4] = '{6'd10, 6'd10, 6'd14, 6'd10};
        int         acc_cyc [8];
        int         acc_n = 0;
        int         rsp_n = 0;
        logic [1:0] exp_id;
        logic [3:0] exp_rdy;
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, OW'(10 + i), OW'(i), i[0]);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 40 && rsp_n < 8; c++) begin
            settle();
            if (req_ready !== 4'b0000 && acc_n < 8) begin
                exp_rdy = 4'b0001 << (acc_n % 4);
                n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant[%0d] got %b want %b", acc_n, req_ready, exp_rdy); end
                acc_cyc[acc_n] = cyc;
                acc_n++;
            end
            if (rsp_valid === 1'b1) begin
                exp_id = 2'(rsp_n % 4);
                n_vec++; if (rsp_id !== exp_id) begin n_err++; $display("FAIL rr_rsp_id[%0d] got %0d want %0d", rsp_n, rsp_id, exp_id); end
                n_vec++; if (rsp_z !== exp_z[exp_id]) begin n_err++; $display("FAIL rr_rsp_z[%0d] got %0d want %0d", rsp_n, rsp_z, exp_z[exp_id]); end
                rsp_n++;
            end
            tick();
        end
        req_valid = 4'b0000;
        n_vec++; if (rsp_n !== 8) begin n_err++; $display("FAIL rr_timeout responses got %0d want 8", rsp_n); end
        for (int k = 1; k < 8; k++) begin
            if (k < acc_n) begin
                n_vec++; if (acc_cyc[k] - acc_cyc[k-1] !== 3) begin n_err++; $display("FAIL rr_spacing[%0d] got %0d want 3", k, acc_cyc[k] - acc_cyc[k-1]); end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rsp_ready = 1'b0;
        set_req(0, 5'd7, 5'd9, 1'b0);
        set_req(3, 5'd20, 5'd30, 1'b1);
        req_valid = 4'b1001;
        settle();
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_first_grant got %b want 0001", req_ready); end
        tick();
        tick();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_rsp_valid got %b want 1", rsp_valid); end
        n_vec++; if (rsp_z !== 6'd16) begin n_err++; $display("FAIL bp_rsp_z got %0d want 16", rsp_z); end
        n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL bp_rsp_id got %0d want 0", rsp_id); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, rsp_valid); end
            n_vec++; if (rsp_z !== 6'd16) begin n_err++; $display("FAIL bp_hold_z[%0d] got %0d want 16", i, rsp_z); end
            n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL bp_hold_id[%0d] got %0d want 0", i, rsp_id); end
            n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_hold_ready[%0d] got %b want 0000", i, req_ready); end
        end
        rsp_ready = 1'b1;
        tick();
        n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_next_grant got %b want 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        n_vec++; if (rsp_z !== 6'd54) begin n_err++; $display("FAIL bp_second_z got %0d want 54", rsp_z); end
        n_vec++; if (rsp_id !== 2'd3) begin n_err++; $display("FAIL bp_second_id got %0d want 3", rsp_id); end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        rsp_ready = 1'b1;
        set_req(2, 5'd3, 5'd5, 1'b1);
        set_req(0, 5'd5, 5'd4, 1'b1);
        req_valid = 4'b0100;
        settle();
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rst_exec_grant got %b want 0100", req_ready); end
        tick();
        // Now in EXEC for requester 2; reset lands on the edge ending this cycle.
        reset     = 1'b1;
        req_valid = 4'b0000;
        tick();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_exec_valid got %b want 0", rsp_valid); end
        n_vec++; if (rsp_z !== 6'd0) begin n_err++; $display("FAIL rst_exec_z got %0d want 0", rsp_z); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_exec_no_pulse[%0d] got %b want 0", i, rsp_valid); end
        end
        req_valid = 4'b0101;
        settle();
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_exec_regrant got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rst_exec_rsp_valid got %b want 1", rsp_valid); end
        n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL rst_exec_rsp_id got %0d want 0", rsp_id); end
        n_vec++; if (rsp_z !== 6'd1) begin n_err++; $display("FAIL rst_exec_rsp_z got %0d want 1", rsp_z); end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_x     = '0;
        req_y     = '0;
        req_sel   = 4'b0000;
        rsp_ready = 1'b0;
        test_reset();
        test_sub_negative();
        test_add_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
